// File: rtl/acc_alu_pkg.sv
// Shared types for the accumulator ALU: opcodes, the flag set, FSM states
// and the opcode-group masks used by the flag logic.
package acc_alu_pkg;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDA = 4'h1,
      OP_LDR = 4'h2,
      OP_ADD = 4'h3,
      OP_SUB = 4'h4,
      OP_ADC = 4'h5,
      OP_SBC = 4'h6,
      OP_AND = 4'h7,
      OP_OR  = 4'h8,
      OP_XOR = 4'h9,
      OP_SHL = 4'hA,
      OP_SHR = 4'hB,
      OP_MUL = 4'hC,
      OP_MOV = 4'hD,
      OP_OUT = 4'hE,
      OP_CLR = 4'hF
   } op_e;

   typedef struct packed {
      logic cf;
      logic zf;
      logic nf;
      logic vf;
   } flags_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

   // One bit per opcode: set when the opcode belongs to the group.
   localparam logic [15:0] IS_ARITH   = 16'h0078;
   localparam logic [15:0] IS_LOGIC   = 16'h0380;
   localparam logic [15:0] WRITES_ACC = 16'h1FFA;

   function automatic logic op_in(input logic [15:0] grp, input op_e op);
      return grp[op];
   endfunction

endpackage

// File: rtl/acc_alu_mul.sv
// Shift-add unsigned multiplier, one partial product per cycle for WIDTH cycles.
// done is asserted alongside the last iteration; prod is valid while done is high.
module acc_alu_mul #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   prod
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   psum_q, psum_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   sum;

   always_comb begin
      sum      = psum_q + (mplier_q[0] ? mcand_q : '0);
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      mcand_d  = mcand_q;
      psum_d   = psum_q;
      mplier_d = mplier_q;
      if (start && !busy_q) begin
         busy_d   = 1'b1;
         cnt_d    = CW'(WIDTH - 1);
         mcand_d  = {{WIDTH{1'b0}}, a};
         mplier_d = b;
         psum_d   = '0;
      end else if (busy_q) begin
         psum_d   = sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         if (cnt_q == '0) begin
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         mcand_q  <= '0;
         psum_q   <= '0;
         mplier_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         mcand_q  <= mcand_d;
         psum_q   <= psum_d;
         mplier_q <= mplier_d;
      end
   end

   assign busy = busy_q;
   assign done = busy_q && (cnt_q == '0);
   assign prod = sum;

endmodule

// File: rtl/acc_alu_seq.sv
// Accumulator ALU with operand register file, flags, OUT result port and a
// multi-cycle multiply. Commands arrive over a valid/ready port.
//   state   | meaning
//   IDLE    | ready; single-cycle ops complete on the accepting edge
//   MUL     | multiplier iterating; commands are held off
module acc_alu_seq
   import acc_alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREGS = 4,
   localparam int SELW = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [SELW-1:0]   cmd_sel,
   input  logic [WIDTH-1:0]  cmd_data,
   output logic [WIDTH-1:0]  acc,
   output logic              res_valid,
   output logic [WIDTH-1:0]  res_data,
   output logic              cf,
   output logic              zf,
   output logic              nf,
   output logic              vf
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               res_valid_q, res_valid_d;
   logic [WIDTH-1:0]   regs_q [NREGS];
   logic [WIDTH-1:0]   regs_d [NREGS];
   flags_t             flg_q, flg_d;

   op_e                op;
   logic [WIDTH-1:0]   r_val;
   logic               accept;
   logic [WIDTH:0]     arith;
   logic               vf_arith;
   logic               mul_busy, mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   assign op        = op_e'(cmd_op);
   assign r_val     = regs_q[cmd_sel];
   assign cmd_ready = (state_q == ST_IDLE) && !mul_busy;
   assign accept    = cmd_valid && cmd_ready;

   acc_alu_mul #(.WIDTH(WIDTH)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (accept && (op == OP_MUL)),
      .a     (acc_q),
      .b     (r_val),
      .busy  (mul_busy),
      .done  (mul_done),
      .prod  (mul_prod)
   );

   // Borrow falls out of bit WIDTH because the unsigned operands are zero-extended.
   always_comb begin
      unique case (op)
         OP_ADD:  arith = {1'b0, acc_q} + {1'b0, r_val};
         OP_ADC:  arith = {1'b0, acc_q} + {1'b0, r_val} + {{WIDTH{1'b0}}, flg_q.cf};
         OP_SUB:  arith = {1'b0, acc_q} - {1'b0, r_val};
         OP_SBC:  arith = {1'b0, acc_q} - {1'b0, r_val} - {{WIDTH{1'b0}}, flg_q.cf};
         default: arith = '0;
      endcase
      if (op == OP_SUB || op == OP_SBC) begin
         vf_arith = (acc_q[WIDTH-1] != r_val[WIDTH-1]) && (arith[WIDTH-1] != acc_q[WIDTH-1]);
      end else begin
         vf_arith = (acc_q[WIDTH-1] == r_val[WIDTH-1]) && (arith[WIDTH-1] != acc_q[WIDTH-1]);
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      res_d       = res_q;
      res_valid_d = 1'b0;
      regs_d      = regs_q;
      flg_d       = flg_q;
      if (state_q == ST_MUL) begin
         if (mul_done) begin
            acc_d    = mul_prod[WIDTH-1:0];
            flg_d.cf = |mul_prod[2*WIDTH-1:WIDTH];
            flg_d.vf = 1'b0;
            flg_d.zf = (acc_d == '0);
            flg_d.nf = acc_d[WIDTH-1];
            state_d  = ST_IDLE;
         end
      end else if (accept) begin
         if (op_in(IS_ARITH, op)) begin
            acc_d    = arith[WIDTH-1:0];
            flg_d.cf = arith[WIDTH];
            flg_d.vf = vf_arith;
         end
         if (op_in(IS_LOGIC, op)) begin
            flg_d.vf = 1'b0;
         end
         case (op)
            OP_LDA: acc_d = cmd_data;
            OP_LDR: regs_d[cmd_sel] = cmd_data;
            OP_AND: acc_d = acc_q & r_val;
            OP_OR:  acc_d = acc_q | r_val;
            OP_XOR: acc_d = acc_q ^ r_val;
            OP_SHL: begin
               acc_d    = {acc_q[WIDTH-2:0], 1'b0};
               flg_d.cf = acc_q[WIDTH-1];
               flg_d.vf = 1'b0;
            end
            OP_SHR: begin
               acc_d    = {1'b0, acc_q[WIDTH-1:1]};
               flg_d.cf = acc_q[0];
               flg_d.vf = 1'b0;
            end
            OP_MUL: state_d = ST_MUL;
            OP_MOV: regs_d[cmd_sel] = acc_q;
            OP_OUT: begin
               res_d       = acc_q;
               res_valid_d = 1'b1;
            end
            OP_CLR: begin
               acc_d = '0;
               flg_d = '0;
            end
            default: ;
         endcase
         // MUL updates zf/nf when its result lands, not on acceptance.
         if (op_in(WRITES_ACC, op) && op != OP_MUL) begin
            flg_d.zf = (acc_d == '0);
            flg_d.nf = acc_d[WIDTH-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         flg_q       <= '0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
         flg_q       <= flg_d;
         regs_q      <= regs_d;
      end
   end

   assign acc       = acc_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_q;
   assign cf        = flg_q.cf;
   assign zf        = flg_q.zf;
   assign nf        = flg_q.nf;
   assign vf        = flg_q.vf;

endmodule
